// File: rtl/vreg_group_scoreboard_if.sv
// Issue, writeback-done and read-done bundle between the sequencer/back end and the register-group scoreboard.
// Latency: none (wires only); backpressure: issue_ready_o qualifies issue_valid_i.
interface vreg_group_scoreboard_if #(
  parameter int unsigned NrVReg   = 32,
  parameter int unsigned NrWbPort = 4,
  parameter int unsigned NrRdPort = 6
);
  localparam int unsigned AW = $clog2(NrVReg);

  logic                             issue_valid_i;
  logic                             issue_ready_o;
  logic                             issue_use_vd_i;
  logic                             issue_use_vs1_i;
  logic                             issue_use_vs2_i;
  logic [AW-1:0]                    issue_vd_i;
  logic [AW-1:0]                    issue_vs1_i;
  logic [AW-1:0]                    issue_vs2_i;
  logic [1:0]                       issue_emul_i;
  logic [NrWbPort-1:0]              wb_done_i;
  logic [NrWbPort-1:0][AW-1:0]      wb_vd_i;
  logic [NrWbPort-1:0][1:0]         wb_emul_i;
  logic [NrRdPort-1:0]              rd_done_i;
  logic [NrRdPort-1:0][AW-1:0]      rd_vs_i;
  logic [NrRdPort-1:0][1:0]         rd_emul_i;
  logic                             busy_o;
  logic                             err_underflow_o;
  logic [31:0]                      stall_raw_cnt_o;
  logic [31:0]                      stall_waw_cnt_o;
  logic [31:0]                      stall_war_cnt_o;
  logic [31:0]                      stall_sat_cnt_o;

  modport master (
    output issue_valid_i, issue_use_vd_i, issue_use_vs1_i, issue_use_vs2_i,
           issue_vd_i, issue_vs1_i, issue_vs2_i, issue_emul_i,
           wb_done_i, wb_vd_i, wb_emul_i, rd_done_i, rd_vs_i, rd_emul_i,
    input  issue_ready_o, busy_o, err_underflow_o,
           stall_raw_cnt_o, stall_waw_cnt_o, stall_war_cnt_o, stall_sat_cnt_o
  );

  modport slave (
    input  issue_valid_i, issue_use_vd_i, issue_use_vs1_i, issue_use_vs2_i,
           issue_vd_i, issue_vs1_i, issue_vs2_i, issue_emul_i,
           wb_done_i, wb_vd_i, wb_emul_i, rd_done_i, rd_vs_i, rd_emul_i,
    output issue_ready_o, busy_o, err_underflow_o,
           stall_raw_cnt_o, stall_waw_cnt_o, stall_war_cnt_o, stall_sat_cnt_o
  );
endinterface

// File: rtl/vreg_group_scoreboard.sv
// Register-group RAW/WAW/WAR hazard scoreboard with per-register reader counters; stall stats under VREG_SB_STALL_STATS_EN.
// Latency: grant/done updates take effect at the next clk_i edge; issue_ready_o is combinational from registered state.
// Backpressure: issue_ready_o drops on any hazard or reader-counter saturation; a request may wait with valid held.
module vreg_group_scoreboard #(
  parameter int unsigned NrVReg         = 32,
  parameter int unsigned NrWbPort       = 4,
  parameter int unsigned NrRdPort       = 6,
  parameter int unsigned ReaderCntWidth = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  vreg_group_scoreboard_if.slave sb
);
  localparam int unsigned AW = $clog2(NrVReg);
  localparam int unsigned CW = ReaderCntWidth;
  localparam logic [CW-1:0] CntMax   = {CW{1'b1}};
  localparam logic [CW-1:0] CntMaxM1 = {{(CW-1){1'b1}}, 1'b0};

  typedef logic [NrVReg-1:0] vmask_t;

  // Misaligned bases are aligned down by masking off the low emul bits.
  function automatic vmask_t grp_mask(input logic [AW-1:0] base, input logic [1:0] emul);
    logic [AW-1:0] keep;
    vmask_t        m;
    keep = ~((AW'(1) << emul) - AW'(1));
    m    = '0;
    for (int i = 0; i < NrVReg; i++) begin
      m[i] = ((AW'(i) & keep) == (base & keep));
    end
    return m;
  endfunction

  vmask_t          writing_q, writing_d;
  logic [CW-1:0]   reading_q [NrVReg];
  logic [CW-1:0]   reading_d [NrVReg];
  logic            err_q;
  logic            underflow;

  vmask_t          vd_m, vs1_m, vs2_m, src_m, wr_clr;
  vmask_t          nz, at_max, near_max;
  vmask_t          wb_m [NrWbPort];
  vmask_t          rd_m [NrRdPort];
  logic            haz_waw, haz_war, haz_raw, haz_sat;
  logic            issue_ready, grant;

  assign vd_m  = {NrVReg{sb.issue_use_vd_i}}  & grp_mask(sb.issue_vd_i,  sb.issue_emul_i);
  assign vs1_m = {NrVReg{sb.issue_use_vs1_i}} & grp_mask(sb.issue_vs1_i, sb.issue_emul_i);
  assign vs2_m = {NrVReg{sb.issue_use_vs2_i}} & grp_mask(sb.issue_vs2_i, sb.issue_emul_i);
  assign src_m = vs1_m | vs2_m;

  for (genvar k = 0; k < NrWbPort; k++) begin : g_wb
    assign wb_m[k] = {NrVReg{sb.wb_done_i[k]}} & grp_mask(sb.wb_vd_i[k], sb.wb_emul_i[k]);
  end
  for (genvar k = 0; k < NrRdPort; k++) begin : g_rd
    assign rd_m[k] = {NrVReg{sb.rd_done_i[k]}} & grp_mask(sb.rd_vs_i[k], sb.rd_emul_i[k]);
  end

  always_comb begin
    nz       = '0;
    at_max   = '0;
    near_max = '0;
    for (int i = 0; i < NrVReg; i++) begin
      nz[i]       = (reading_q[i] != '0);
      at_max[i]   = (reading_q[i] == CntMax);
      near_max[i] = (reading_q[i] >= CntMaxM1);
    end
  end

  // Hazards look only at registered state, so done ports never reach issue_ready_o.
  assign haz_waw = |(vd_m & writing_q);
  assign haz_war = |(vd_m & nz);
  assign haz_raw = |(src_m & writing_q);
  assign haz_sat = (|(src_m & at_max)) | (|(vs1_m & vs2_m & near_max));

  assign issue_ready = !rst_ni || !(haz_waw || haz_war || haz_raw || haz_sat);
  assign grant       = rst_ni && sb.issue_valid_i && issue_ready;

  always_comb begin
    int unsigned dec;
    int unsigned cur;
    wr_clr = '0;
    for (int k = 0; k < NrWbPort; k++) begin
      wr_clr = wr_clr | wb_m[k];
    end
    writing_d = (writing_q & ~wr_clr) | (grant ? vd_m : '0);
    underflow = 1'b0;
    for (int i = 0; i < NrVReg; i++) begin
      dec = 0;
      for (int k = 0; k < NrRdPort; k++) begin
        dec = dec + 32'(rd_m[k][i]);
      end
      cur = 32'(reading_q[i]);
      if (dec > cur) begin
        underflow = 1'b1;
        cur       = 0;
      end else begin
        cur = cur - dec;
      end
      if (grant) begin
        cur = cur + 32'(vs1_m[i]) + 32'(vs2_m[i]);
      end
      reading_d[i] = CW'(cur);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      writing_q <= '0;
      reading_q <= '{default: '0};
      err_q     <= 1'b0;
    end else begin
      writing_q <= writing_d;
      reading_q <= reading_d;
      err_q     <= err_q | underflow;
    end
  end

  assign sb.issue_ready_o   = issue_ready;
  assign sb.busy_o          = rst_ni && ((|writing_q) || (|nz));
  assign sb.err_underflow_o = rst_ni && err_q;

`ifdef VREG_SB_STALL_STATS_EN
  logic [31:0] waw_cnt_q, war_cnt_q, raw_cnt_q, sat_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      waw_cnt_q <= '0;
      war_cnt_q <= '0;
      raw_cnt_q <= '0;
      sat_cnt_q <= '0;
    end else if (sb.issue_valid_i && !issue_ready) begin
      if (haz_waw)      waw_cnt_q <= waw_cnt_q + 32'd1;
      else if (haz_war) war_cnt_q <= war_cnt_q + 32'd1;
      else if (haz_raw) raw_cnt_q <= raw_cnt_q + 32'd1;
      else              sat_cnt_q <= sat_cnt_q + 32'd1;
    end
  end

  assign sb.stall_waw_cnt_o = waw_cnt_q;
  assign sb.stall_war_cnt_o = war_cnt_q;
  assign sb.stall_raw_cnt_o = raw_cnt_q;
  assign sb.stall_sat_cnt_o = sat_cnt_q;
`else
  assign sb.stall_waw_cnt_o = '0;
  assign sb.stall_war_cnt_o = '0;
  assign sb.stall_raw_cnt_o = '0;
  assign sb.stall_sat_cnt_o = '0;
`endif
endmodule

// File: tb/tb_vreg_group_scoreboard.sv
// Scoreboard bench for vreg_group_scoreboard: random traffic plus directed hazard cases against a group-level model.
// Stall-statistics expectations follow VREG_SB_STALL_STATS_EN.
module tb_vreg_group_scoreboard;
  localparam int NR = 32, NW = 4, NRD = 6, CW = 3, MAXC = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vreg_group_scoreboard_if #(.NrVReg(NR), .NrWbPort(NW), .NrRdPort(NRD)) sb_if ();
  vreg_group_scoreboard #(.NrVReg(NR), .NrWbPort(NW), .NrRdPort(NRD), .ReaderCntWidth(CW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .sb    (sb_if)
  );

  typedef struct {
    int          cyc;
    bit          rdy, busy, err;
    int unsigned waw, war, raw, sat;
    int          c_rdy, c_err;
    bit          c_st;
    int unsigned c_waw, c_raw;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0, fails = 0, cyc_no = 0;
  bit          wr[NR];
  int          rc[NR];
  bit          err_m;
  int unsigned st_waw, st_war, st_raw, st_sat;
  int          pend_w[$], pend_r[$];

  function automatic bit in_grp(int base, int emul, int r);
    int a;
    a = (base >> emul) << emul;
    return (r >= a) && (r < a + (1 << emul));
  endfunction

  task automatic cmp(string name, int cyc, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at step %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("issue_ready", e.cyc, 32'(sb_if.issue_ready_o), 32'(e.rdy));
      cmp("busy", e.cyc, 32'(sb_if.busy_o), 32'(e.busy));
      cmp("err_underflow", e.cyc, 32'(sb_if.err_underflow_o), 32'(e.err));
      cmp("stall_waw", e.cyc, sb_if.stall_waw_cnt_o, e.waw);
      cmp("stall_war", e.cyc, sb_if.stall_war_cnt_o, e.war);
      cmp("stall_raw", e.cyc, sb_if.stall_raw_cnt_o, e.raw);
      cmp("stall_sat", e.cyc, sb_if.stall_sat_cnt_o, e.sat);
      if (e.c_rdy >= 0) cmp("ready_directed", e.cyc, 32'(sb_if.issue_ready_o), 32'(e.c_rdy));
      if (e.c_err >= 0) cmp("err_directed", e.cyc, 32'(sb_if.err_underflow_o), 32'(e.c_err));
      if (e.c_st) begin
        cmp("waw_directed", e.cyc, sb_if.stall_waw_cnt_o, e.c_waw);
        cmp("raw_directed", e.cyc, sb_if.stall_raw_cnt_o, e.c_raw);
      end
    end
  end

  // Evaluate the request against the model, queue the expectation, then advance the model across the edge.
  task automatic step(input int c_rdy = -1, input int c_err = -1, input bit c_st = 1'b0,
                      input int unsigned c_waw = 0, input int unsigned c_raw = 0);
    exp_t e;
    bit   waw, war, raw, sat, rdy, grant, invd, any;
    int   n, dec, emul;
    waw = 0; war = 0; raw = 0; sat = 0; any = 0;
    emul = int'(sb_if.issue_emul_i);
    for (int r = 0; r < NR; r++) begin
      invd = sb_if.issue_use_vd_i && in_grp(int'(sb_if.issue_vd_i), emul, r);
      n = int'(sb_if.issue_use_vs1_i && in_grp(int'(sb_if.issue_vs1_i), emul, r))
        + int'(sb_if.issue_use_vs2_i && in_grp(int'(sb_if.issue_vs2_i), emul, r));
      waw |= invd && wr[r];
      war |= invd && (rc[r] > 0);
      raw |= (n > 0) && wr[r];
      sat |= (n > 0) && (rc[r] + n > MAXC);
      any |= wr[r] || (rc[r] > 0);
    end
    rdy   = (rst_n == 1'b0) || !(waw || war || raw || sat);
    grant = rst_n && sb_if.issue_valid_i && rdy;
    e.cyc = cyc_no; e.rdy = rdy; e.busy = rst_n && any; e.err = rst_n && err_m;
    e.waw = st_waw; e.war = st_war; e.raw = st_raw; e.sat = st_sat;
    e.c_rdy = c_rdy; e.c_err = c_err; e.c_st = c_st; e.c_waw = c_waw; e.c_raw = c_raw;
    exp_q.push_back(e);

    if (!rst_n) begin
      for (int r = 0; r < NR; r++) begin wr[r] = 0; rc[r] = 0; end
      err_m = 0; st_waw = 0; st_war = 0; st_raw = 0; st_sat = 0;
      pend_w.delete(); pend_r.delete();
    end else begin
`ifdef VREG_SB_STALL_STATS_EN
      if (sb_if.issue_valid_i && !rdy) begin
        if (waw)      st_waw++;
        else if (war) st_war++;
        else if (raw) st_raw++;
        else          st_sat++;
      end
`endif
      for (int r = 0; r < NR; r++) begin
        for (int k = 0; k < NW; k++)
          if (sb_if.wb_done_i[k] && in_grp(int'(sb_if.wb_vd_i[k]), int'(sb_if.wb_emul_i[k]), r)) wr[r] = 0;
        dec = 0;
        for (int k = 0; k < NRD; k++)
          if (sb_if.rd_done_i[k] && in_grp(int'(sb_if.rd_vs_i[k]), int'(sb_if.rd_emul_i[k]), r)) dec++;
        if (dec > rc[r]) begin err_m = 1; rc[r] = 0; end
        else rc[r] -= dec;
        if (grant) begin
          if (sb_if.issue_use_vd_i && in_grp(int'(sb_if.issue_vd_i), emul, r)) wr[r] = 1;
          rc[r] += int'(sb_if.issue_use_vs1_i && in_grp(int'(sb_if.issue_vs1_i), emul, r))
                 + int'(sb_if.issue_use_vs2_i && in_grp(int'(sb_if.issue_vs2_i), emul, r));
        end
      end
      if (grant) begin
        if (sb_if.issue_use_vd_i)  pend_w.push_back(int'(sb_if.issue_vd_i) * 4 + emul);
        if (sb_if.issue_use_vs1_i) pend_r.push_back(int'(sb_if.issue_vs1_i) * 4 + emul);
        if (sb_if.issue_use_vs2_i) pend_r.push_back(int'(sb_if.issue_vs2_i) * 4 + emul);
      end
    end
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.issue_valid_i = 0; sb_if.issue_use_vd_i = 0; sb_if.issue_use_vs1_i = 0; sb_if.issue_use_vs2_i = 0;
    sb_if.issue_vd_i = '0; sb_if.issue_vs1_i = '0; sb_if.issue_vs2_i = '0; sb_if.issue_emul_i = '0;
    sb_if.wb_done_i = '0; sb_if.wb_vd_i = '0; sb_if.wb_emul_i = '0;
    sb_if.rd_done_i = '0; sb_if.rd_vs_i = '0; sb_if.rd_emul_i = '0;
  endtask

  task automatic req(input bit uvd, input int vd, input bit u1, input int s1,
                     input bit u2, input int s2, input int emul);
    sb_if.issue_valid_i = 1;
    sb_if.issue_use_vd_i = uvd; sb_if.issue_vd_i = 5'(vd);
    sb_if.issue_use_vs1_i = u1; sb_if.issue_vs1_i = 5'(s1);
    sb_if.issue_use_vs2_i = u2; sb_if.issue_vs2_i = 5'(s2);
    sb_if.issue_emul_i = 2'(emul);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step(1, 0);
    rst_n = 1;
  endtask

  task automatic rand_cycle();
    int idx, ent;
    int emuls[6];
    emuls = '{0, 0, 1, 1, 2, 3};
    idle();
    sb_if.issue_valid_i   = ($urandom_range(0, 9) < 7);
    sb_if.issue_use_vd_i  = 1'($urandom_range(0, 1));
    sb_if.issue_use_vs1_i = 1'($urandom_range(0, 1));
    sb_if.issue_use_vs2_i = 1'($urandom_range(0, 1));
    sb_if.issue_vd_i  = 5'($urandom_range(0, 15));
    sb_if.issue_vs1_i = 5'($urandom_range(0, 15));
    sb_if.issue_vs2_i = 5'($urandom_range(0, 15));
    sb_if.issue_emul_i = 2'(emuls[$urandom_range(0, 5)]);
    for (int k = 0; k < NW; k++) begin
      if (pend_w.size() > 0 && $urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, pend_w.size() - 1);
        ent = pend_w[idx];
        pend_w.delete(idx);
        sb_if.wb_done_i[k] = 1; sb_if.wb_vd_i[k] = 5'(ent / 4); sb_if.wb_emul_i[k] = 2'(ent % 4);
      end else if ($urandom_range(0, 19) == 0) begin
        sb_if.wb_done_i[k] = 1; sb_if.wb_vd_i[k] = 5'($urandom_range(0, 31)); sb_if.wb_emul_i[k] = 2'($urandom_range(0, 3));
      end
    end
    for (int k = 0; k < NRD; k++) begin
      if (pend_r.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, pend_r.size() - 1);
        ent = pend_r[idx];
        pend_r.delete(idx);
        sb_if.rd_done_i[k] = 1; sb_if.rd_vs_i[k] = 5'(ent / 4); sb_if.rd_emul_i[k] = 2'(ent % 4);
      end
    end
    step();
  endtask

  initial begin
    idle();
    for (int r = 0; r < NR; r++) begin wr[r] = 0; rc[r] = 0; end
    err_m = 0; st_waw = 0; st_war = 0; st_raw = 0; st_sat = 0;
    @(posedge clk);
    #1;
    // Reset with junk on the done and issue ports: all of it must be ignored.
    rst_n = 0;
    req(1, 3, 1, 4, 0, 0, 1);
    sb_if.rd_done_i[0] = 1; sb_if.rd_vs_i[0] = 5'd7;
    step(1, 0);
    step(1, 0);
    rst_n = 1;
    idle();
    step(1, 0);

    for (int i = 0; i < 1500; i++) rand_cycle();
    rst_n = 0;
    rand_cycle();
    rand_cycle();
    rst_n = 1;
    idle();
    step(1, 0);
    for (int i = 0; i < 500; i++) rand_cycle();

    // Group RAW on v8-v9, released by a writeback of the same group.
    do_reset();
    req(1, 8, 0, 0, 0, 0, 1); step(1);
    req(0, 0, 0, 0, 1, 9, 0); step(0); step(0);
    sb_if.wb_done_i[0] = 1; sb_if.wb_vd_i[0] = 5'd8; sb_if.wb_emul_i[0] = 2'd1;
    step(0);
    sb_if.wb_done_i = '0; step(1);
    idle(); step();

    // WAR on v4 with two readers, released one at a time, then both at once.
    do_reset();
    req(0, 0, 1, 4, 1, 4, 0); step(1);
    req(1, 4, 0, 0, 0, 0, 0); step(0);
    sb_if.rd_done_i[0] = 1; sb_if.rd_vs_i[0] = 5'd4; step(0);
    sb_if.rd_done_i = '0; step(0);
    sb_if.rd_done_i[3] = 1; sb_if.rd_vs_i[3] = 5'd4; step(0);
    sb_if.rd_done_i = '0; step(1);
    do_reset();
    req(0, 0, 1, 4, 1, 4, 0); step(1);
    req(1, 4, 0, 0, 0, 0, 0);
    sb_if.rd_done_i[0] = 1; sb_if.rd_vs_i[0] = 5'd4;
    sb_if.rd_done_i[1] = 1; sb_if.rd_vs_i[1] = 5'd4; step(0);
    sb_if.rd_done_i = '0; step(1);

    // Reader-counter saturation on v1.
    do_reset();
    req(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1);
    step(0); step(0);
    sb_if.rd_done_i[2] = 1; sb_if.rd_vs_i[2] = 5'd1; step(0);
    sb_if.rd_done_i = '0; step(1);
    do_reset();
    req(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1);
    req(0, 0, 1, 1, 1, 1, 0); step(0);

    // Writeback and a new write to v2 in the same cycle leave v2 pending.
    do_reset();
    req(1, 2, 0, 0, 0, 0, 0);
    sb_if.wb_done_i[1] = 1; sb_if.wb_vd_i[1] = 5'd2; step(1);
    idle(); req(0, 0, 1, 2, 0, 0, 0); step(0);

    // Underflow on v5 is sticky until reset and leaves the counter at zero.
    do_reset();
    idle();
    sb_if.rd_done_i[5] = 1; sb_if.rd_vs_i[5] = 5'd5; step(-1, 0);
    sb_if.rd_done_i = '0; step(-1, 1); step(-1, 1);
    req(1, 5, 0, 0, 0, 0, 0); step(1, 1);
    idle(); step(-1, 1);
    rst_n = 0; step(1, 0);
    rst_n = 1; step(-1, 0);

`ifdef VREG_SB_STALL_STATS_EN
    do_reset();
    req(1, 3, 0, 0, 0, 0, 0); step(1);
    step(0); step(0); step(0);
    req(0, 0, 1, 3, 0, 0, 0); step(0); step(0);
    idle(); step(-1, -1, 1'b1, 3, 2);
`endif

    idle();
    step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
